// File: rtl/data_memory_unit.sv
// Data memory for the MEM stage: a DEPTH x 32 word array with a fixed
// multi-cycle access time. Each accepted access stalls the pipeline for
// exactly LATENCY cycles, commits on the edge that ends the last stall
// cycle, and is followed by one DONE cycle in which no new request is
// taken. Misaligned or contradictory requests are rejected with a
// one-cycle err pulse and never stall.
//
//   state | meaning
//   IDLE  | waiting for a request; a legal one stalls this same cycle
//   BUSY  | access in flight, stall held, counter running down
//   DONE  | access committed, pipeline advances, inputs ignored
module data_memory_unit #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rd_valid,
  output logic        stall,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_op_q, rd_op_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] mem_q [DEPTH];

  logic          req;
  logic          valid_req;
  logic [AW-1:0] idx;
  logic          commit;
  logic          commit_rd;
  logic          mem_we;
  logic          unused_addr;

  // Address decode and request qualification; upper address bits wrap.
  always_comb begin
    idx         = addr[AW+1:2];
    unused_addr = ^addr[31:AW+2];
    req         = MemRead | MemWrite;
    valid_req   = (MemRead ^ MemWrite) && (addr[1:0] == 2'b00);
  end

  // Commit happens in the last stall cycle: the request cycle itself when
  // LATENCY is 1, otherwise the BUSY cycle whose counter is about to hit 0.
  always_comb begin
    commit    = 1'b0;
    commit_rd = rd_op_q;
    if (state_q == IDLE) begin
      commit    = valid_req && (LATENCY == 1);
      commit_rd = MemRead;
    end else if (state_q == BUSY) begin
      commit    = (cnt_q == 4'd1);
    end
    mem_we     = commit && !commit_rd;
    rd_valid_d = commit && commit_rd;
    rdata_d    = (commit && commit_rd) ? mem_q[idx] : rdata_q;
  end

  // State register plus registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rd_op_q    <= 1'b0;
      rdata_q    <= 32'h0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_op_q    <= rd_op_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array; reset clears every word so an aborted write leaves nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (mem_we) begin
      mem_q[idx] <= wdata;
    end
  end

  // Next-state logic; the counter holds the number of BUSY cycles remaining.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_op_d = rd_op_q;
    case (state_q)
      IDLE: begin
        if (valid_req) begin
          cnt_d   = LAT_M1;
          rd_op_d = MemRead;
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; stall and err are suppressed while reset is asserted.
  always_comb begin
    stall    = !reset && (((state_q == IDLE) && valid_req) || (state_q == BUSY));
    err      = !reset && (state_q == IDLE) && req && !valid_req;
    rdata    = rdata_q;
    rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: a reference memory model predicts read data,
// predicted values are queued when a read is issued and compared when the
// DUT pulses rd_valid; stall/err timing is checked cycle by cycle.
module tb_data_memory_unit;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        stall;
  logic        err;

  int          pass_cnt;
  int          total_cnt;
  logic [31:0] model [DEPTH];
  logic [31:0] sb [$];
  logic [31:0] exp_rdata;

  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .stall    (stall),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    sb.delete();
    exp_rdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard whenever the DUT reports fresh read data.
  task automatic check_read_data(input string name);
    logic [31:0] e;
    if (rd_valid === 1'b1) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL %s: rd_valid with no read outstanding, rdata=%h", name, rdata);
      end else begin
        e = sb.pop_front();
        exp_rdata = e;
        if (rdata !== e) $display("FAIL %s rdata: got %h expected %h", name, rdata, e);
        else pass_cnt++;
      end
    end
  endtask

  // One access from IDLE; returns at posedge+1 with the DUT back in IDLE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input string name);
    logic legal;
    int   widx;
    legal = (rd ^ wr) && (a[1:0] == 2'b00);
    widx  = int'(a[AW+1:2]);
    MemRead = rd; MemWrite = wr; addr = a; wdata = d;
    if (legal) begin
      if (rd) sb.push_back(model[widx]);
      else    model[widx] = d;
      for (int i = 0; i < LAT; i++) begin
        #1;
        total_cnt++;
        if (stall !== 1'b1 || err !== 1'b0)
          $display("FAIL %s stall cycle %0d: stall=%b err=%b expected stall=1 err=0", name, i, stall, err);
        else pass_cnt++;
        step();
      end
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      total_cnt++;
      if (stall !== 1'b0 || rd_valid !== rd)
        $display("FAIL %s done cycle: stall=%b rd_valid=%b expected stall=0 rd_valid=%b", name, stall, rd_valid, rd);
      else pass_cnt++;
      check_read_data(name);
      step();
    end else begin
      #1;
      total_cnt++;
      if (err !== 1'b1 || stall !== 1'b0)
        $display("FAIL %s reject: err=%b stall=%b expected err=1 stall=0", name, err, stall);
      else pass_cnt++;
      step();
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      total_cnt++;
      if (err !== 1'b0 || stall !== 1'b0 || rd_valid !== 1'b0 || rdata !== exp_rdata)
        $display("FAIL %s after reject: err=%b stall=%b rd_valid=%b rdata=%h expected 0/0/0/%h",
                 name, err, stall, rd_valid, rdata, exp_rdata);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h10; wdata = 32'h0;
    #1;
    total_cnt++;
    if (stall !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_outputs: stall=%b err=%b expected 0/0", stall, err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rdata !== 32'h0 || rd_valid !== 1'b0)
      $display("FAIL reset_state: rdata=%h rd_valid=%b expected 00000000/0", rdata, rd_valid);
    else pass_cnt++;
    reset = 1'b0; MemRead = 1'b0;
    clear_model();
    step();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (stall !== 1'b0 || err !== 1'b0 || rd_valid !== 1'b0)
        $display("FAIL idle cycle %0d: stall=%b err=%b rd_valid=%b expected 0/0/0", i, stall, err, rd_valid);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_read_after_reset();
    access(1'b1, 1'b0, 32'h10, 32'h0, "read_0x10");
  endtask

  task automatic test_write_read();
    access(1'b0, 1'b1, 32'h24, 32'hDEADBEEF, "write_0x24");
    access(1'b1, 1'b0, 32'h24, 32'h0, "read_0x24");
  endtask

  task automatic test_wrap();
    access(1'b0, 1'b1, 32'h04, 32'h12345678, "write_0x04");
    access(1'b1, 1'b0, 32'h104, 32'h0, "read_0x104_wrap");
  endtask

  task automatic test_errors();
    access(1'b1, 1'b0, 32'h06, 32'h0, "misaligned_read");
    access(1'b1, 1'b1, 32'h08, 32'h0, "both_rd_wr");
    access(1'b0, 1'b1, 32'h0B, 32'h55555555, "misaligned_write");
    access(1'b1, 1'b0, 32'h08, 32'h0, "read_after_bad_write");
  endtask

  task automatic test_reset_mid_access();
    MemRead = 1'b0; MemWrite = 1'b1; addr = 32'h30; wdata = 32'hAAAA5555;
    #1;
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL midreset first stall: stall=%b expected 1", stall);
    else pass_cnt++;
    step();
    reset = 1'b1;
    #1;
    total_cnt++;
    if (stall !== 1'b0 || err !== 1'b0)
      $display("FAIL midreset during reset: stall=%b err=%b expected 0/0", stall, err);
    else pass_cnt++;
    step();
    reset = 1'b0; MemWrite = 1'b0;
    clear_model();
    #1;
    total_cnt++;
    if (stall !== 1'b0 || rd_valid !== 1'b0 || rdata !== 32'h0)
      $display("FAIL midreset after: stall=%b rd_valid=%b rdata=%h expected 0/0/00000000", stall, rd_valid, rdata);
    else pass_cnt++;
    step();
    access(1'b1, 1'b0, 32'h30, 32'h0, "read_0x30_after_abort");
  endtask

  task automatic test_back_to_back();
    int pulses;
    int phase;
    logic exp_stall;
    logic exp_rdv;
    pulses = 0;
    access(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, "write_0x10");
    MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h10;
    for (int k = 0; k < 3 * (LAT + 1); k++) begin
      phase     = k % (LAT + 1);
      exp_stall = (phase < LAT);
      exp_rdv   = (phase == LAT);
      if (phase == 0) sb.push_back(model[int'(addr[AW+1:2])]);
      #1;
      total_cnt++;
      if (stall !== exp_stall || rd_valid !== exp_rdv)
        $display("FAIL b2b cycle %0d: stall=%b rd_valid=%b expected %b/%b", k, stall, rd_valid, exp_stall, exp_rdv);
      else pass_cnt++;
      if (rd_valid === 1'b1) pulses++;
      check_read_data("b2b");
      step();
    end
    MemRead = 1'b0;
    total_cnt++;
    if (pulses != 3) $display("FAIL b2b pulse count: got %0d expected 3", pulses);
    else pass_cnt++;
    step();
    sb.delete();
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a;
    for (int n = 0; n < 24; n++) begin
      op = $urandom_range(0, 4);
      a  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      case (op)
        0, 1: access(1'b1, 1'b0, a, 32'h0, "rand_read");
        2, 3: access(1'b0, 1'b1, a, $urandom, "rand_write");
        default: access(1'b1, 1'b0, a | 32'h2, 32'h0, "rand_misaligned");
      endcase
    end
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = 32'h0; wdata = 32'h0;
    clear_model();
    step();
    test_reset();
    test_idle();
    test_read_after_reset();
    test_write_read();
    test_wrap();
    test_errors();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    test_idle();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL scoreboard drain: %0d reads never returned, expected 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 Parameters SHALL be: DEPTH, default 64, number of 32-bit words (power of 2); LATENCY, default 2, stall cycles per access (1..15).
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemRead  input  1  read request from the EX/MEM pipeline register.
REQ-005 MemWrite  input  1  write request from the EX/MEM pipeline register.
REQ-006 addr  input  32  byte address (ALU result).
REQ-007 wdata  input  32  store data.
REQ-008 rdata  output  32  load data; drives DataMEM_RD_MEM of the MEM/WB register.
REQ-009 rd_valid  output  1  one-cycle pulse, high when rdata is newly updated.
REQ-010 stall  output  1  high SHALL freeze the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-011 err  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-012 Storage SHALL be DEPTH x 32 bits; word index = addr[log2(DEPTH)+1:2]; higher address bits ignored (wrap modulo DEPTH words).
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; the state register is the only source of sequencing.
REQ-014 Request = MemRead or MemWrite, sampled only in IDLE.
REQ-015 IDLE, valid request (exactly one of MemRead/MemWrite, addr[1:0]=00): stall SHALL assert combinationally that cycle; the counter loads LATENCY-1; next state BUSY, or DONE when LATENCY=1.
REQ-016 BUSY: stall=1; counter decrements each cycle; at count 0 next state DONE.
REQ-017 Total stall SHALL be exactly LATENCY consecutive cycles, starting in the request cycle.
REQ-018 Commit SHALL happen on the edge that ends the last stall cycle, using the addr/wdata values held stable by upstream; writes update the array; reads load rdata.
REQ-019 DONE: stall=0; rd_valid=1 if the commit was a read; inputs SHALL be ignored (no re-accept while the pipeline advances); next state IDLE.
REQ-020 Back-to-back accesses SHALL therefore be separated by the DONE cycle: minimum LATENCY+1 cycles per access.
REQ-021 Misaligned request (addr[1:0]!=00) in IDLE: no access; stall stays 0; err=1 for that cycle (combinational); state stays IDLE.
REQ-022 MemRead and MemWrite both high in IDLE: treated as illegal; same response as REQ-021.
REQ-023 No request in IDLE: stall=0, err=0, no state change.
REQ-024 rdata SHALL hold its value until the next committed read; writes and errors never alter it.
REQ-025 A read at the same address as the immediately preceding write SHALL return the written data (no stale read).

Reset
REQ-026 On reset: state IDLE, counter 0, rdata 32'h0, rd_valid 0, all DEPTH words cleared to 0; stall and err SHALL be 0 during the reset cycle.
REQ-027 Reset mid-access (BUSY or the final stall cycle) SHALL abort: a pending write is not performed and rdata is not updated.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-029 After reset, read addr 0x10 (LATENCY=2) -> stall high for 2 cycles; next cycle rd_valid=1, rdata=0x00000000.
REQ-030 Write 0xDEADBEEF to 0x24, then read 0x24 -> stall 2 cycles per access, one DONE gap, rdata=0xDEADBEEF with rd_valid pulse.
REQ-031 Write 0x12345678 to 0x04, then read 0x104 (wraps, DEPTH=64) -> rdata=0x12345678.
REQ-032 Read addr 0x06, then MemRead=MemWrite=1 at 0x08 -> err pulses 1 cycle each, stall stays 0, rdata unchanged.
REQ-033 Write 0xAAAA5555 to 0x30, reset asserted in the 2nd stall cycle, then read 0x30 -> rdata=0x00000000.
REQ-034 Hold MemRead=1, addr 0x10 steady across DONE -> exactly one rd_valid pulse per LATENCY+1 cycles, never two consecutive.
